// File: rtl/regfile_loader.sv
// Streams words into the register file write port (FIRST_REG..LAST_REG, ascending)
// while holding the core, with abort support and a running checksum of accepted words.
module regfile_loader #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned FIRST_REG = 1,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              core_hold,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [DATA_W-1:0] sum_n;
    logic              accept;

    // Next-state, handshake and checksum update
    always_comb begin
        state_n  = state;
        addr_n   = addr;
        sum_n    = checksum;
        accept   = 1'b0;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_n = LOAD;
                    addr_n  = FIRST_A;
                    sum_n   = '0;
                end
            end
            LOAD: begin
                in_ready = !abort;
                if (abort) begin
                    state_n = IDLE;
                end else if (in_valid) begin
                    accept = 1'b1;
                    sum_n  = checksum + in_data;
                    if (addr == LAST_A) begin
                        state_n = FLUSH;
                        addr_n  = FIRST_A;
                    end else begin
                        addr_n = addr + ADDR_W'(1);
                    end
                end
            end
            FLUSH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and registered outputs; the write lands one cycle after its accept
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            addr      <= FIRST_A;
            checksum  <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            done      <= 1'b0;
            core_hold <= 1'b0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            checksum  <= sum_n;
            rf_we     <= accept;
            done      <= (state_n == FLUSH);
            core_hold <= (state_n != IDLE);
            if (accept) begin
                rf_waddr <= addr;
                rf_wdata <= in_data;
            end
        end
    end

endmodule
